// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, access sizes and grant ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requesters.
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate on contention instead of fixed data priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_grant_i,
`endif
  output logic valid_o,
  output logic grant_o
);

  always_comb begin
    valid_o = if_req_i | d_req_i;
    grant_o = GRANT_FETCH;
    if (if_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_o = ~last_grant_i;
`else
      grant_o = GRANT_DATA;
`endif
    end else if (d_req_i) begin
      grant_o = GRANT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memReady-handshaked memory, one at a time.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention (default: data wins).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifAck,
  output logic [DATA_W-1:0] ifRdata,
  input  logic              dReq,
  input  logic              dWrite,
  input  logic [1:0]        dSize,
  input  logic              dSign,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdata,
  input  logic              memReady,
  output logic              memExecute,
  output logic              memWrite,
  output logic [1:0]        memSize,
  output logic              memSign,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  output logic              grantId,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              exec_q, exec_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic pick_valid;
  logic pick_grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  mem_arb_pick u_pick (
    .if_req_i     (ifReq),
    .d_req_i      (dReq),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .valid_o      (pick_valid),
    .grant_o      (pick_grant)
  );

  always_comb begin
    state_d    = state_q;
    exec_d     = exec_q;
    write_d    = write_q;
    size_d     = size_q;
    sign_d     = sign_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    grant_d    = grant_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          exec_d  = 1'b1;
          state_d = StIssue;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = pick_grant;
`endif
          if (pick_grant == GRANT_DATA) begin
            write_d = dWrite;
            size_d  = dSize;
            sign_d  = dSign;
            addr_d  = dAddr;
            wdata_d = dWdata;
          end else begin
            // Fetches are always unsigned word reads.
            write_d = 1'b0;
            size_d  = SIZE_WORD;
            sign_d  = 1'b0;
            addr_d  = ifAddr;
          end
        end
      end
      StIssue: begin
        // Memory may skip one execute during its restart cycle, so hold until it goes busy.
        if (!memReady) begin
          exec_d  = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (memReady) begin
          if (!write_q) begin
            if (grant_q == GRANT_DATA) begin
              d_rdata_d = memRdata;
            end else begin
              if_rdata_d = memRdata;
            end
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      exec_q     <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= SIZE_WORD;
      sign_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      grant_q    <= GRANT_FETCH;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= GRANT_FETCH;
`endif
    end else begin
      state_q    <= state_d;
      exec_q     <= exec_d;
      write_q    <= write_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      grant_q    <= grant_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign memExecute = exec_q;
  assign memWrite   = write_q;
  assign memSize    = size_q;
  assign memSign    = sign_q;
  assign memAddress = addr_q;
  assign memWdata   = wdata_q;
  assign grantId    = grant_q;
  assign busy       = (state_q != StIdle);
  assign ifRdata    = if_rdata_q;
  assign dRdata     = d_rdata_q;
  assign ifAck      = (state_q == StDone) && (grant_q == GRANT_FETCH);
  assign dAck       = (state_q == StDone) && (grant_q == GRANT_DATA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory (RAM + LED/7-seg MMIO) behind it.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [31:0] MmioAddr = 32'h0001_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          ifReq;
  logic [AW-1:0] ifAddr;
  logic          ifAck;
  logic [DW-1:0] ifRdata;
  logic          dReq;
  logic          dWrite;
  logic [1:0]    dSize;
  logic          dSign;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic          dAck;
  logic [DW-1:0] dRdata;
  logic          memReady;
  logic          memExecute;
  logic          memWrite;
  logic [1:0]    memSize;
  logic          memSign;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;
  logic          grantId;
  logic          busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ifReq      (ifReq),
    .ifAddr     (ifAddr),
    .ifAck      (ifAck),
    .ifRdata    (ifRdata),
    .dReq       (dReq),
    .dWrite     (dWrite),
    .dSize      (dSize),
    .dSign      (dSign),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .dAck       (dAck),
    .dRdata     (dRdata),
    .memReady   (memReady),
    .memExecute (memExecute),
    .memWrite   (memWrite),
    .memSize    (memSize),
    .memSign    (memSign),
    .memAddress (memAddress),
    .memWdata   (memWdata),
    .memRdata   (memRdata),
    .grantId    (grantId),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Behavioural memory: accepts execute while ready, then stays busy for two cycles.
  logic [7:0] ram [0:4095];
  logic       led_state;
  logic [6:0] seven_seg;
  int         mem_cnt;

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg);
    logic [11:0] i;
    logic [7:0]  b;
    logic [15:0] h;
    i = a[11:0];
    b = ram[i];
    h = {ram[i + 12'd1], ram[i]};
    case (sz)
      SIZE_BYTE: return sg ? {{24{b[7]}}, b} : {24'd0, b};
      SIZE_HALF: return sg ? {{16{h[15]}}, h} : {16'd0, h};
      default:   return {ram[i + 12'd3], ram[i + 12'd2], h};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      memReady  <= 1'b1;
      memRdata  <= '0;
      mem_cnt   <= 0;
      led_state <= 1'b0;
      seven_seg <= '0;
      ram[12'h010] <= 8'hEF;
      ram[12'h011] <= 8'hBE;
      ram[12'h012] <= 8'hAD;
      ram[12'h013] <= 8'hDE;
    end else if (memReady && memExecute) begin
      memReady <= 1'b0;
      mem_cnt  <= 1;
      if (memAddress == MmioAddr) begin
        if (memWrite) begin
          led_state <= memWdata[0];
          seven_seg <= memWdata[7:1];
        end
        memRdata <= '0;
      end else if (memWrite) begin
        ram[memAddress[11:0]] <= memWdata[7:0];
        if (memSize != SIZE_BYTE) ram[memAddress[11:0] + 12'd1] <= memWdata[15:8];
        if (memSize == SIZE_WORD) begin
          ram[memAddress[11:0] + 12'd2] <= memWdata[23:16];
          ram[memAddress[11:0] + 12'd3] <= memWdata[31:24];
        end
      end else begin
        memRdata <= load_val(memAddress, memSize, memSign);
      end
    end else if (!memReady) begin
      if (mem_cnt == 0) memReady <= 1'b1;
      else mem_cnt <= mem_cnt - 1;
    end
  end

  // Protocol checker: mem* stable while busy, single-cycle and exclusive acks.
  logic          p_busy, p_if_ack, p_d_ack, p_write, p_sign;
  logic [1:0]    p_size;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  always @(negedge clk) begin
    if (!reset) begin
      if (busy && p_busy) begin
        check("stable_addr", memAddress, p_addr);
        check("stable_wdata", memWdata, p_wdata);
        check("stable_ctl", {memWrite, memSize, memSign}, {p_write, p_size, p_sign});
      end
      if (ifAck || dAck) check("ack_exclusive", ifAck & dAck, 0);
      if (p_if_ack) check("ifack_width", ifAck, 0);
      if (p_d_ack) check("dack_width", dAck, 0);
    end
    p_busy   <= busy;
    p_if_ack <= ifAck;
    p_d_ack  <= dAck;
    p_addr   <= memAddress;
    p_wdata  <= memWdata;
    p_write  <= memWrite;
    p_size   <= memSize;
    p_sign   <= memSign;
  end

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        chk;
    string       tag;
  } exp_t;

  exp_t sb[$];
  logic tb_last = GRANT_FETCH;

  function automatic void push(input logic port, input logic [31:0] data, input logic chk,
                               input string tag);
    exp_t e;
    e.port = port;
    e.data = data;
    e.chk  = chk;
    e.tag  = tag;
    sb.push_back(e);
  endfunction

  task automatic drive_if(input logic [31:0] a);
    ifAddr = a;
    ifReq  = 1'b1;
  endtask

  task automatic drive_d(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    dWrite = w;
    dSize  = sz;
    dSign  = sg;
    dAddr  = a;
    dWdata = wd;
    dReq   = 1'b1;
  endtask

  // Waits for 'want' acks, scoring each against the queue; returns cycles to the last ack.
  task automatic run_acks(input int want, input int max_cycles, output int cycles);
    int   got;
    logic p;
    exp_t e;
    got    = 0;
    cycles = 0;
    while (got < want && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
      if (ifAck || dAck) begin
        got++;
        p = dAck ? GRANT_DATA : GRANT_FETCH;
        if (sb.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_port"}, p, e.port);
          if (e.chk) check({e.tag, "_data"}, p ? dRdata : ifRdata, e.data);
        end
        tb_last = p;
        if (ifAck) ifReq = 1'b0;
        if (dAck) dReq = 1'b0;
      end
    end
    if (got < want) check("ack_timeout", got, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   acks;
    logic first;

    reset  = 1'b1;
    ifReq  = 1'b0;
    ifAddr = '0;
    dReq   = 1'b0;
    dWrite = 1'b0;
    dSize  = SIZE_WORD;
    dSign  = 1'b0;
    dAddr  = '0;
    dWdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_exec", memExecute, 0);
    check("rst_acks", {ifAck, dAck}, 0);
    check("rst_grant", grantId, 0);
    check("rst_ctl", {memWrite, memSize, memSign}, {1'b0, SIZE_WORD, 1'b0});
    check("rst_addr", memAddress, 0);
    check("rst_wdata", memWdata, 0);
    check("rst_rdata", {ifRdata, dRdata} == 64'd0, 1);

    // Fetch only, latency from IDLE sample to ack.
    drive_if(32'h10);
    push(GRANT_FETCH, 32'hDEAD_BEEF, 1'b1, "fetch");
    run_acks(1, 20, cyc);
    check("fetch_latency", cyc, 5);
    @(negedge clk);

    // Byte store then signed and unsigned byte loads.
    drive_d(1'b1, SIZE_BYTE, 1'b0, 32'h20, 32'h1A5);
    push(GRANT_DATA, 32'h0, 1'b0, "store");
    run_acks(1, 20, cyc);
    check("store_latency", cyc, 5);
    @(negedge clk);
    drive_d(1'b0, SIZE_BYTE, 1'b1, 32'h20, 32'h0);
    push(GRANT_DATA, 32'hFFFF_FFA5, 1'b1, "lb_signed");
    run_acks(1, 20, cyc);
    @(negedge clk);
    drive_d(1'b0, SIZE_BYTE, 1'b0, 32'h20, 32'h0);
    push(GRANT_DATA, 32'h0000_00A5, 1'b1, "lb_unsigned");
    run_acks(1, 20, cyc);
    check("fetch_rdata_held", ifRdata, 32'hDEAD_BEEF);
    @(negedge clk);

    // Contention: two rounds, both ports raised together.
    for (int r = 0; r < 2; r++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      first = ~tb_last;
`else
      first = GRANT_DATA;
`endif
      drive_if(32'h10);
      drive_d(1'b0, SIZE_BYTE, 1'b0, 32'h20, 32'h0);
      if (first == GRANT_DATA) begin
        push(GRANT_DATA, 32'hA5, 1'b1, "cont_first");
        push(GRANT_FETCH, 32'hDEAD_BEEF, 1'b1, "cont_second");
      end else begin
        push(GRANT_FETCH, 32'hDEAD_BEEF, 1'b1, "cont_first");
        push(GRANT_DATA, 32'hA5, 1'b1, "cont_second");
      end
      run_acks(2, 40, cyc);
      check("cont_drained", sb.size(), 0);
      @(negedge clk);
    end

    // MMIO store and readback.
    drive_d(1'b1, SIZE_WORD, 1'b0, MmioAddr, 32'h3);
    push(GRANT_DATA, 32'h0, 1'b0, "mmio_store");
    run_acks(1, 20, cyc);
    check("mmio_led", led_state, 1);
    check("mmio_seg", seven_seg, 7'h01);
    @(negedge clk);
    drive_d(1'b0, SIZE_WORD, 1'b0, MmioAddr, 32'h0);
    push(GRANT_DATA, 32'h0, 1'b1, "mmio_load");
    run_acks(1, 20, cyc);
    @(negedge clk);

    // Request dropped early still completes.
    drive_if(32'h10);
    push(GRANT_FETCH, 32'hDEAD_BEEF, 1'b1, "early_drop");
    repeat (2) @(negedge clk);
    ifReq = 1'b0;
    run_acks(1, 20, cyc);
    @(negedge clk);

    // Reset while in WAIT abandons the transaction silently.
    drive_d(1'b0, SIZE_BYTE, 1'b1, 32'h20, 32'h0);
    repeat (3) @(negedge clk);
    check("wait_busy", busy, 1);
    reset = 1'b1;
    dReq  = 1'b0;
    @(negedge clk);
    reset   = 1'b0;
    tb_last = GRANT_FETCH;
    check("rst_wait_busy", busy, 0);
    check("rst_wait_exec", memExecute, 0);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifAck || dAck) acks++;
    end
    check("rst_wait_no_ack", acks, 0);
    drive_if(32'h10);
    push(GRANT_FETCH, 32'hDEAD_BEEF, 1'b1, "post_reset");
    run_acks(1, 20, cyc);
    check("post_reset_latency", cyc, 5);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
